trena_seq_uc: RTL and testbench
===============================

Name: trena_seq_uc

Overview:
- Parametrised control unit for the distance-measurement and serial-report subsystem.
- One `mensurar` command runs NUM_MEDIDAS measure/transmit rounds:
  - each round triggers a sonar measurement;
  - then it sends NUM_CHARS characters over the serial TX, one handshake per character.
- Adds a measurement timeout with an error state, an inter-round interval and continuous (auto-repeat) mode.
- Sits between the top-level command inputs, the sonar interface and the serial TX; it drives the character-select mux directly through `indice_char`.

Parameters:
- NUM_CHARS, default 4: characters per measurement report (>=1).
- NUM_MEDIDAS, default 1: measurements per command (>=1).
- INTERVALO_CYCLES, default 50: idle cycles between rounds (>=1).
- TIMEOUT_CYCLES, default 1000000: maximum cycles spent in MEDE before error (>=2).

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- mensurar, input, 1: start command, level-sampled in idle states.
- modo_continuo, input, 1: auto-repeat enable, sampled in FINAL.
- pronto_medida, input, 1: sonar result valid pulse.
- pronto_transmissao, input, 1: serial TX done pulse.
- zera, output, 1: clear the external datapath.
- medir, output, 1: one-cycle sonar trigger.
- partida_serial, output, 1: one-cycle TX start.
- indice_char, output, CW: current character index, with CW = max(1, clog2(NUM_CHARS)).
- indice_medida, output, MW: current round, with MW = max(1, clog2(NUM_MEDIDAS)).
- pronto, output, 1: command complete.
- erro_timeout, output, 1: measurement timeout flag.
- db_estado, output, 4: state code for debug.

Behaviour:
- Reset:
  - Synchronous and active-high, effective on the clock edge where reset=1; this includes reset mid-operation.
  - After reset: state INICIAL (0x0), all counters = 0, all outputs 0 except zera=1 and db_estado=0x0.
- Outputs:
  - All control outputs are Moore decodes of the state register.
  - indice_char and indice_medida are registered counters.
- States and transitions (codes in brackets):
  - INICIAL (0): go to PREP if mensurar.
  - PREP (1): medir=1, zera=1; clear indice_char and the timeout timer. Next state MEDE.
  - MEDE (2):
    - if pronto_medida, go to ENVIA;
    - otherwise, if the timer = TIMEOUT_CYCLES-1, go to ERRO;
    - otherwise increment the timer.
    - pronto_medida wins on the same cycle as the timeout.
  - ENVIA (3): partida_serial=1. Next state AGUARDA.
  - AGUARDA (4): wait for pronto_transmissao, then:
    - if indice_char != NUM_CHARS-1, go to PROX;
    - else if indice_medida != NUM_MEDIDAS-1, go to INTERVALO;
    - else go to FINAL.
  - PROX (5): indice_char += 1. Next state ENVIA.
  - INTERVALO (6):
    - count INTERVALO_CYCLES cycles (counter cleared on entry);
    - at the last cycle, go to PREP and increment indice_medida;
    - on an interval entered from FINAL, indice_medida is cleared instead.
  - FINAL (7): pronto=1.
    - if modo_continuo, go to INTERVALO (new command, round 0);
    - else if mensurar, go to PREP with indice_medida cleared;
    - otherwise stay.
  - ERRO (8): erro_timeout=1; go to PREP with indice_medida cleared when mensurar=1.
  - Codes 9-15 are illegal and go to INICIAL on the next cycle.
- zera=1 in INICIAL and PREP only.
- Latency:
  - mensurar sampled in INICIAL gives medir at the next edge; pronto_medida gives partida_serial 1 cycle later.
  - Per character: ENVIA + AGUARDA(>=1) + PROX, so a minimum of 3 cycles per character.
- Boundary conditions:
  - pronto_transmissao outside AGUARDA and pronto_medida outside MEDE are ignored.
  - mensurar is ignored while busy (states 1-6).
  - With NUM_CHARS=1, indice_char stays 0 and PROX is never entered.
  - With NUM_MEDIDAS=1, round-to-round INTERVALO is never entered; it is only used by continuous mode.
  - Counters never wrap: they are bounded by the compare values above.

Optional Feature:
- Macro: TRENA_TIMEOUT_EN.
- Defined:
  - the timeout timer and ERRO state exist exactly as described above.
- Undefined:
  - no timer is synthesised;
  - MEDE waits indefinitely for pronto_medida;
  - erro_timeout is tied 0;
  - ERRO is unreachable, and code 8 is treated as illegal (goes to INICIAL).

Test Plan:
- Full report, NUM_CHARS=4, NUM_MEDIDAS=1:
  - Stimulus: reset, then mensurar pulse; pronto_medida 5 cycles after medir; pronto_transmissao 3 cycles after each partida_serial.
  - Response: exactly 4 partida_serial pulses with indice_char 0,1,2,3; then pronto=1 and db_estado=7.
- Multiple rounds, NUM_MEDIDAS=3, INTERVALO_CYCLES=10:
  - Response: 3 medir pulses, each at least 10 cycles after the previous round's last TX done; indice_medida 0,1,2; 12 TX starts total; pronto after the last.
- Timeout (macro defined, TIMEOUT_CYCLES=20):
  - Stimulus: no pronto_medida.
  - Response: erro_timeout=1 exactly 20 cycles after entering MEDE; pronto stays 0.
  - A subsequent mensurar gives medir and clears erro_timeout.
- Simultaneity (macro defined):
  - Stimulus: pronto_medida asserted on the timeout cycle.
  - Response: ENVIA is entered and erro_timeout stays 0.
- Continuous mode:
  - Stimulus: modo_continuo=1 held.
  - Response: after FINAL, medir re-fires INTERVALO_CYCLES+1 cycles later with indice_medida=0; stray pronto_transmissao pulses during MEDE are ignored.
- Reset mid-TX:
  - Stimulus: assert reset during AGUARDA of char 2.
  - Response: next edge gives db_estado=0, indice_char=0, zera=1, partida_serial=0.

Source files
------------

// File: rtl/trena_seq_uc.sv
// rtl/trena_seq_uc.sv - measure/transmit round sequencer for the sonar serial report
// Define TRENA_TIMEOUT_EN to build the MEDE timeout timer and the ERRO state.
module trena_seq_uc #(
  parameter int NUM_CHARS        = 4,
  parameter int NUM_MEDIDAS      = 1,
  parameter int INTERVALO_CYCLES = 50,
  parameter int TIMEOUT_CYCLES   = 1000000,
  localparam int CW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1,
  localparam int MW = (NUM_MEDIDAS > 1) ? $clog2(NUM_MEDIDAS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mensurar,
  input  logic          modo_continuo,
  input  logic          pronto_medida,
  input  logic          pronto_transmissao,
  output logic          zera,
  output logic          medir,
  output logic          partida_serial,
  output logic [CW-1:0] indice_char,
  output logic [MW-1:0] indice_medida,
  output logic          pronto,
  output logic          erro_timeout,
  output logic [3:0]    db_estado
);

  localparam int IW = $clog2(INTERVALO_CYCLES + 1);
  localparam logic [CW-1:0] CHAR_LAST = CW'(NUM_CHARS - 1);
  localparam logic [MW-1:0] MED_LAST  = MW'(NUM_MEDIDAS - 1);
  localparam logic [IW-1:0] INT_LAST  = IW'(INTERVALO_CYCLES - 1);

  if (NUM_CHARS < 1 || NUM_MEDIDAS < 1 || INTERVALO_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("trena_seq_uc: parameter out of range");
  end

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREP      = 4'd1,
    MEDE      = 4'd2,
    ENVIA     = 4'd3,
    AGUARDA   = 4'd4,
    PROX      = 4'd5,
    INTERVALO = 4'd6,
    FINAL     = 4'd7,
    ERRO      = 4'd8
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] char_q, char_d;
  logic [MW-1:0] medida_q, medida_d;
  logic [IW-1:0] int_q, int_d;
  // set when the running interval was started from FINAL (new command, round 0)
  logic          from_final_q, from_final_d;

`ifdef TRENA_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  always_comb begin
    estado_d     = estado_q;
    char_d       = char_q;
    medida_d     = medida_q;
    int_d        = int_q;
    from_final_d = from_final_q;
`ifdef TRENA_TIMEOUT_EN
    timer_d      = timer_q;
`endif
    case (estado_q)
      INICIAL: begin
        if (mensurar) begin
          estado_d = PREP;
          medida_d = '0;
        end
      end
      PREP: begin
        estado_d = MEDE;
        char_d   = '0;
`ifdef TRENA_TIMEOUT_EN
        timer_d  = '0;
`endif
      end
      MEDE: begin
        if (pronto_medida) begin
          estado_d = ENVIA;
        end
`ifdef TRENA_TIMEOUT_EN
        else if (timer_q == TMO_LAST) begin
          estado_d = ERRO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      ENVIA: estado_d = AGUARDA;
      AGUARDA: begin
        if (pronto_transmissao) begin
          if (char_q != CHAR_LAST) begin
            estado_d = PROX;
          end else if (medida_q != MED_LAST) begin
            estado_d     = INTERVALO;
            int_d        = '0;
            from_final_d = 1'b0;
          end else begin
            estado_d = FINAL;
          end
        end
      end
      PROX: begin
        char_d   = char_q + 1'b1;
        estado_d = ENVIA;
      end
      INTERVALO: begin
        if (int_q == INT_LAST) begin
          estado_d = PREP;
          medida_d = from_final_q ? '0 : medida_q + 1'b1;
        end else begin
          int_d = int_q + 1'b1;
        end
      end
      FINAL: begin
        if (modo_continuo) begin
          estado_d     = INTERVALO;
          int_d        = '0;
          from_final_d = 1'b1;
        end else if (mensurar) begin
          estado_d = PREP;
          medida_d = '0;
        end
      end
`ifdef TRENA_TIMEOUT_EN
      ERRO: begin
        if (mensurar) begin
          estado_d = PREP;
          medida_d = '0;
        end
      end
`endif
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= INICIAL;
      char_q       <= '0;
      medida_q     <= '0;
      int_q        <= '0;
      from_final_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      char_q       <= char_d;
      medida_q     <= medida_d;
      int_q        <= int_d;
      from_final_q <= from_final_d;
    end
  end

`ifdef TRENA_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
  assign erro_timeout = (estado_q == ERRO);
`else
  assign erro_timeout = 1'b0;
`endif

  assign zera           = (estado_q == INICIAL) || (estado_q == PREP);
  assign medir          = (estado_q == PREP);
  assign partida_serial = (estado_q == ENVIA);
  assign pronto         = (estado_q == FINAL);
  assign indice_char    = char_q;
  assign indice_medida  = medida_q;
  assign db_estado      = estado_q;

endmodule

// File: tb/tb_trena_seq_uc.sv
// tb/tb_trena_seq_uc.sv - randomized timeline-model bench for trena_seq_uc
// Honours TRENA_TIMEOUT_EN the same way as the design.
module tb_trena_seq_uc;

  localparam int MAXC = 8000;
  localparam int TO   = 20;
`ifdef TRENA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int S_INI = 0, S_PREP = 1, S_MEDE = 2, S_ENVIA = 3, S_AGUARDA = 4;
  localparam int S_PROX = 5, S_INT = 6, S_FINAL = 7, S_ERRO = 8;

  int cfg_nc [2] = '{4, 1};
  int cfg_nm [2] = '{3, 1};
  int cfg_iv [2] = '{10, 3};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_s [2];
  logic       men_s [2];
  logic       mc_s  [2];
  logic       pm_s  [2];
  logic       pt_s  [2];
  logic       zera_s [2];
  logic       medir_s [2];
  logic       part_s [2];
  logic       pronto_s [2];
  logic       erro_s [2];
  logic [3:0] db_s [2];
  logic [1:0] ic_a, im_a;
  logic       ic_b, im_b;

  trena_seq_uc #(.NUM_CHARS(4), .NUM_MEDIDAS(3), .INTERVALO_CYCLES(10), .TIMEOUT_CYCLES(TO)) dut_a (
    .clock(clock), .reset(rst_s[0]), .mensurar(men_s[0]), .modo_continuo(mc_s[0]),
    .pronto_medida(pm_s[0]), .pronto_transmissao(pt_s[0]), .zera(zera_s[0]), .medir(medir_s[0]),
    .partida_serial(part_s[0]), .indice_char(ic_a), .indice_medida(im_a), .pronto(pronto_s[0]),
    .erro_timeout(erro_s[0]), .db_estado(db_s[0])
  );

  trena_seq_uc #(.NUM_CHARS(1), .NUM_MEDIDAS(1), .INTERVALO_CYCLES(3), .TIMEOUT_CYCLES(TO)) dut_b (
    .clock(clock), .reset(rst_s[1]), .mensurar(men_s[1]), .modo_continuo(mc_s[1]),
    .pronto_medida(pm_s[1]), .pronto_transmissao(pt_s[1]), .zera(zera_s[1]), .medir(medir_s[1]),
    .partida_serial(part_s[1]), .indice_char(ic_b), .indice_medida(im_b), .pronto(pronto_s[1]),
    .erro_timeout(erro_s[1]), .db_estado(db_s[1])
  );

  // Expected timeline: row c is what the outputs must show after clock edge c,
  // given the inputs of row c sampled at that edge.
  int exp_s  [2][MAXC];
  int exp_ic [2][MAXC];
  int exp_im [2][MAXC];
  bit in_rst [2][MAXC];
  bit in_men [2][MAXC];
  bit in_mc  [2][MAXC];
  bit in_pm  [2][MAXC];
  bit in_pt  [2][MAXC];
  int tl [2];
  int ic_m [2];
  int im_m [2];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input int k, input int s);
    if (tl[k] < MAXC) begin
      exp_s[k][tl[k]]  = s;
      exp_ic[k][tl[k]] = ic_m[k];
      exp_im[k][tl[k]] = im_m[k];
      tl[k]++;
    end
  endtask

  function automatic int cur(input int k);
    return exp_s[k][tl[k]-1];
  endfunction

  task automatic idle(input int k, input int n);
    int s;
    s = cur(k);
    repeat (n) push(k, s);
  endtask

  // One command: rounds of measure + NUM_CHARS characters; may end in FINAL,
  // ERRO (timeout round) or INICIAL (reset during a character wait).
  task automatic run_cmd(input int k, input bit via_int, input int sim_r, input int tmo_r, input int rst_r);
    int nc, nm, iv, dm, rc;
    nc = cfg_nc[k];
    nm = cfg_nm[k];
    iv = cfg_iv[k];
    rc = (nc > 2) ? 2 : nc - 1;
    if (via_int) begin
      in_mc[k][tl[k]] = 1'b1;
      repeat (iv) push(k, S_INT);
    end else begin
      in_men[k][tl[k]] = 1'b1;
    end
    im_m[k] = 0;
    push(k, S_PREP);
    for (int r = 0; r < nm; r++) begin
      ic_m[k] = 0;
      if (r == tmo_r)      dm = TO + 1 + $urandom_range(0, 5);
      else if (r == sim_r) dm = TO;
      else                 dm = $urandom_range(1, 8);
      if (TO_EN && dm > TO) begin
        repeat (TO) push(k, S_MEDE);
        push(k, S_ERRO);
        return;
      end
      repeat (dm) push(k, S_MEDE);
      for (int c = 0; c < nc; c++) begin
        if (c == 0) in_pm[k][tl[k]] = 1'b1;
        ic_m[k] = c;
        push(k, S_ENVIA);
        if (r == rst_r && c == rc) begin
          push(k, S_AGUARDA);
          in_rst[k][tl[k]] = 1'b1;
          ic_m[k] = 0;
          im_m[k] = 0;
          push(k, S_INI);
          return;
        end
        repeat ($urandom_range(1, 4)) push(k, S_AGUARDA);
        in_pt[k][tl[k]] = 1'b1;
        if (c != nc - 1) push(k, S_PROX);
      end
      if (r != nm - 1) begin
        repeat (iv) push(k, S_INT);
        im_m[k] = im_m[k] + 1;
        push(k, S_PREP);
      end else begin
        push(k, S_FINAL);
      end
    end
  endtask

  task automatic build(input int k);
    int p;
    bit vi;
    tl[k] = 0;
    ic_m[k] = 0;
    im_m[k] = 0;
    in_rst[k][0] = 1'b1;
    push(k, S_INI);
    idle(k, 3);
    run_cmd(k, 1'b0, 0, -1, -1);          idle(k, 4);
    run_cmd(k, 1'b1, -1, -1, -1);         idle(k, 2);
    run_cmd(k, 1'b0, -1, cfg_nm[k]-1, -1); idle(k, 5);
    run_cmd(k, 1'b0, -1, -1, -1);         idle(k, 2);
    run_cmd(k, 1'b0, -1, -1, cfg_nm[k]-1); idle(k, 3);
    repeat (8) begin
      vi = (cur(k) == S_FINAL) && ($urandom_range(0, 1) == 1);
      run_cmd(k, vi,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, cfg_nm[k]-1)) : -1,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, cfg_nm[k]-1)) : -1,
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, cfg_nm[k]-1)) : -1);
      idle(k, $urandom_range(1, 4));
    end
    // Stray inputs wherever the previous state must ignore them.
    for (int c = 1; c < tl[k]; c++) begin
      p = exp_s[k][c-1];
      if (p != S_AGUARDA) in_pt[k][c] = ($urandom_range(0, 3) == 0);
      if (p != S_MEDE)    in_pm[k][c] = ($urandom_range(0, 3) == 0);
      if (p >= S_PREP && p <= S_INT) in_men[k][c] = ($urandom_range(0, 2) == 0);
      if (p != S_FINAL)   in_mc[k][c] = ($urandom_range(0, 1) == 0);
    end
  endtask

  function automatic logic [12:0] exp_word(input int k, input int c);
    int s;
    s = exp_s[k][c];
    return {4'(s), 2'(exp_ic[k][c]), 2'(exp_im[k][c]),
            (s == S_INI) || (s == S_PREP), s == S_PREP, s == S_ENVIA, s == S_FINAL, s == S_ERRO};
  endfunction

  function automatic logic [12:0] act_word(input int k);
    if (k == 0)
      return {db_s[0], ic_a, im_a, zera_s[0], medir_s[0], part_s[0], pronto_s[0], erro_s[0]};
    return {db_s[1], 1'b0, ic_b, 1'b0, im_b, zera_s[1], medir_s[1], part_s[1], pronto_s[1], erro_s[1]};
  endfunction

  int n_part [2] = '{0, 0};
  int n_medir [2] = '{0, 0};
  bit first_done [2] = '{1'b0, 1'b0};
  int mede_start = 0;
  int tmo_gap = -1;
  int n_erro = 0;
  logic [3:0] db_prev = 4'd0;
  logic erro_prev = 1'b0;

  initial begin
    int len;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; men_s[k] = 1'b0; mc_s[k] = 1'b0; pm_s[k] = 1'b0; pt_s[k] = 1'b0;
    end
    build(0);
    build(1);
    len = (tl[0] > tl[1]) ? tl[0] : tl[1];
    for (int c = 0; c < len; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (c < tl[k]) begin
          rst_s[k] = in_rst[k][c]; men_s[k] = in_men[k][c]; mc_s[k] = in_mc[k][c];
          pm_s[k] = in_pm[k][c];   pt_s[k] = in_pt[k][c];
        end else begin
          rst_s[k] = 1'b0; men_s[k] = 1'b0; mc_s[k] = 1'b0; pm_s[k] = 1'b0; pt_s[k] = 1'b0;
        end
      end
      @(posedge clock);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (c < tl[k]) begin
          check($sformatf("dut%0d row %0d {db,ic,im,zera,medir,tx,pronto,erro}", k, c),
                int'(act_word(k)), int'(exp_word(k, c)));
          if (!first_done[k]) begin
            n_part[k]  += int'(part_s[k]);
            n_medir[k] += int'(medir_s[k]);
            if (db_s[k] == 4'd7) first_done[k] = 1'b1;
          end
        end
      end
      if (db_s[0] == 4'd2 && db_prev == 4'd1) mede_start = c;
      if (erro_s[0] && !erro_prev) begin
        n_erro++;
        if (tmo_gap < 0) tmo_gap = c - mede_start;
      end
      db_prev = db_s[0];
      erro_prev = erro_s[0];
      if (n_fails >= 40) break;
    end
    check("dut0 first command TX starts", n_part[0], 12);
    check("dut0 first command medir pulses", n_medir[0], 3);
    check("dut1 first command TX starts", n_part[1], 1);
    check("dut1 first command medir pulses", n_medir[1], 1);
`ifdef TRENA_TIMEOUT_EN
    check("dut0 cycles from MEDE entry to erro_timeout", tmo_gap, TO);
`else
    check("dut0 erro_timeout pulses without timeout build", n_erro, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
